// File: rtl/fb_pkg.sv
// Shared types and default sizing for the frame-buffer pixel write path.
package fb_pkg;

    localparam int unsigned IMG_W_DEF  = 320;
    localparam int unsigned IMG_H_DEF  = 240;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 17;

    localparam int unsigned COL_W_DEF  = $clog2(IMG_W_DEF);
    localparam int unsigned ROW_W_DEF  = $clog2(IMG_H_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } wr_state_e;

    // Counter width for a count of n positions, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pix_pos_counter.sv
// Column/row position and linear frame offset of the next pixel to be written.
module pix_pos_counter
    import fb_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              adv_i,
    input  logic              eol_i,
    output logic [ADDR_W-1:0] offset_o,
    output logic              col_last_c_o,
    output logic              last_pixel_c_o
);

    localparam int unsigned COL_W = cnt_w(IMG_W);
    localparam int unsigned ROW_W = cnt_w(IMG_H);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              line_end_c;

    assign col_last_c_o   = (col_q == COL_W'(IMG_W - 1));
    assign line_end_c     = col_last_c_o || eol_i;
    assign last_pixel_c_o = (row_q == ROW_W'(IMG_H - 1)) && line_end_c;
    assign offset_o       = offset_q;

    // Clear with advance means the pixel at offset 0 is being consumed now.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        offset_d    = offset_q;
        line_base_d = line_base_q;
        if (clr_i) begin
            col_d       = adv_i ? COL_W'(1) : '0;
            row_d       = '0;
            offset_d    = adv_i ? ADDR_W'(1) : '0;
            line_base_d = '0;
        end else if (adv_i) begin
            if (line_end_c) begin
                col_d       = '0;
                row_d       = row_q + ROW_W'(1);
                line_base_d = line_base_q + ADDR_W'(IMG_W);
                offset_d    = line_base_q + ADDR_W'(IMG_W);
            end else begin
                col_d    = col_q + COL_W'(1);
                offset_d = offset_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            offset_q    <= '0;
            line_base_q <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            offset_q    <= offset_d;
            line_base_q <= line_base_d;
        end
    end

endmodule

// File: rtl/pixel_write_ctrl.sv
// Frame capture sequencer: arms on start, syncs to SOF and writes each accepted
// pixel to base_addr + linear offset, flagging line-length and SOF framing errors.
module pixel_write_ctrl
    import fb_pkg::*;
#(
    parameter int unsigned IMG_W  = IMG_W_DEF,
    parameter int unsigned IMG_H  = IMG_H_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_sof,
    input  logic              pix_eol,
    output logic              pix_ready,
    input  logic              mem_ready,
    output logic              writepixel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              err_line,
    output logic              err_frame
);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              err_line_q, err_line_d;
    logic              err_frame_q, err_frame_d;
    logic              wp_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              busy_q;
    logic              done_q;

    logic              accept_c;
    logic              wr_en_c;
    logic              wr_sof_c;
    logic              cnt_clr_c;
    logic              cnt_adv_c;
    logic [ADDR_W-1:0] offset_c;
    logic [ADDR_W-1:0] wr_off_c;
    logic              col_last_c;
    logic              last_pixel_c;

    pix_pos_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_pos (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr_i          (cnt_clr_c),
        .adv_i          (cnt_adv_c),
        .eol_i          (pix_eol),
        .offset_o       (offset_c),
        .col_last_c_o   (col_last_c),
        .last_pixel_c_o (last_pixel_c)
    );

    // Ready is combinational so backpressure from the frame buffer stalls the stream at once.
    assign pix_ready = (state_q == ARMED) || ((state_q == WRITE) && mem_ready);
    assign accept_c  = pix_valid && pix_ready;
    assign wr_off_c  = wr_sof_c ? '0 : offset_c;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        err_line_d  = err_line_q;
        err_frame_d = err_frame_q;
        wr_en_c     = 1'b0;
        wr_sof_c    = 1'b0;
        cnt_clr_c   = 1'b0;
        cnt_adv_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    err_line_d  = 1'b0;
                    err_frame_d = 1'b0;
                    cnt_clr_c   = 1'b1;
                    state_d     = ARMED;
                end
            end
            ARMED: begin
                if (accept_c && pix_sof) begin
                    wr_en_c   = 1'b1;
                    wr_sof_c  = 1'b1;
                    cnt_clr_c = 1'b1;
                    cnt_adv_c = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (accept_c) begin
                    wr_en_c = 1'b1;
                    if (pix_sof) begin
                        // Resynchronise: this pixel becomes offset 0 of a fresh frame.
                        err_frame_d = 1'b1;
                        wr_sof_c    = 1'b1;
                        cnt_clr_c   = 1'b1;
                        cnt_adv_c   = 1'b1;
                    end else begin
                        cnt_adv_c = 1'b1;
                        if (pix_eol != col_last_c) begin
                            err_line_d = 1'b1;
                        end
                        if (last_pixel_c) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
            wp_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
            wp_q        <= wr_en_c;
            if (wr_en_c) begin
                addr_q  <= base_q + wr_off_c;
                wdata_q <= pix_data;
            end
            busy_q      <= (state_d == ARMED) || (state_d == WRITE);
            done_q      <= (state_d == DONE);
        end
    end

    assign writepixel = wp_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign err_line   = err_line_q;
    assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_pixel_write_ctrl.sv
// Directed bench for pixel_write_ctrl with a 4x3 image; a second 4-bit-address
// instance on the same stream covers frame-buffer address wrap.
module tb_pixel_write_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [16:0] base_addr;
    logic [3:0]  base_w;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_sof;
    logic        pix_eol;
    logic        mem_ready;

    logic        pix_ready, writepixel, busy, frame_done, err_line, err_frame;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;

    logic        pix_ready_w, writepixel_w, busy_w, frame_done_w, err_line_w, err_frame_w;
    logic [3:0]  mem_addr_w;
    logic [7:0]  mem_wdata_w;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_done = 0;
    int done_cyc = -1;
    int last_wr_cyc = -2;
    int n_done_w = 0;

    logic [16:0] wa[$];
    logic [7:0]  wd[$];
    logic [3:0]  wwa[$];
    logic [7:0]  wwd[$];

    always #5 clk = ~clk;

    pixel_write_ctrl #(.IMG_W(4), .IMG_H(3), .DATA_W(8), .ADDR_W(17)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_ready(pix_ready), .mem_ready(mem_ready), .writepixel(writepixel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .frame_done(frame_done),
        .err_line(err_line), .err_frame(err_frame)
    );

    pixel_write_ctrl #(.IMG_W(4), .IMG_H(3), .DATA_W(8), .ADDR_W(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_w),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_ready(pix_ready_w), .mem_ready(mem_ready), .writepixel(writepixel_w),
        .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w), .busy(busy_w), .frame_done(frame_done_w),
        .err_line(err_line_w), .err_frame(err_frame_w)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done monitor sampled mid-cycle.
    always @(negedge clk) begin
        if (writepixel) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            last_wr_cyc <= cyc;
        end
        if (frame_done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
        if (writepixel_w) begin
            wwa.push_back(mem_addr_w);
            wwd.push_back(mem_wdata_w);
        end
        if (frame_done_w) n_done_w <= n_done_w + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        @(negedge clk);
        wa.delete(); wd.delete(); wwa.delete(); wwd.delete();
        n_done = 0; n_done_w = 0; done_cyc = -1; last_wr_cyc = -2;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] d, input logic sof, input logic eol);
        int n;
        n = 0;
        pix_valid = 1'b1; pix_data = d; pix_sof = sof; pix_eol = eol;
        @(negedge clk);
        while (!pix_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'(pix_ready), 32'd1);
        @(posedge clk); #1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] first);
        for (int i = 0; i < 12; i++) send_pix(8'(first + 8'(i)), i == 0, (i % 4) == 3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got time-out expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [16:0] ea;
        logic [3:0]  ew;
        rst_n = 1'b0; start = 1'b0; base_addr = 17'h100; base_w = 4'hE;
        pix_valid = 1'b0; pix_data = '0; pix_sof = 1'b0; pix_eol = 1'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Reset state
        check("rst_writepixel", 32'(writepixel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pix_ready", 32'(pix_ready), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_errs", {30'd0, err_line, err_frame}, 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_wrap_ready_busy", {30'd0, pix_ready_w, busy_w}, 0);

        // Clean frame (also the base-wrap case on the 4-bit instance)
        clear_log();
        do_start();
        check("clean_busy", 32'(busy), 1);
        check("clean_armed_ready", 32'(pix_ready), 1);
        send_frame(8'h00);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("clean_start_in_done_ignored", 32'(busy), 0);
        idle(2);
        check("clean_nwr", 32'(wa.size()), 12);
        for (int i = 0; i < 12; i++) begin
            ea = 17'h100 + 17'(i);
            ew = 4'(14 + i);
            check($sformatf("clean_addr%0d", i), 32'(wa[i]), 32'(ea));
            check($sformatf("clean_data%0d", i), 32'(wd[i]), 32'(i));
            check($sformatf("wrap_addr%0d", i), 32'(wwa[i]), 32'(ew));
        end
        check("wrap_nwr", 32'(wwa.size()), 12);
        check("wrap_data_last", 32'(wwd[11]), 32'h0B);
        check("wrap_done", 32'(n_done_w), 1);
        check("wrap_errs", {30'd0, err_line_w, err_frame_w}, 0);
        check("clean_done_cnt", 32'(n_done), 1);
        check("clean_done_with_last_write", 32'(done_cyc), 32'(last_wr_cyc));
        check("clean_errs", {30'd0, err_line, err_frame}, 0);

        // Pre-SOF garbage
        clear_log();
        do_start();
        for (int i = 0; i < 3; i++) send_pix(8'hA0 + 8'(i), 1'b0, 1'b0);
        send_frame(8'h10);
        idle(3);
        check("garb_nwr", 32'(wa.size()), 12);
        check("garb_first_addr", 32'(wa[0]), 32'h100);
        check("garb_first_data", 32'(wd[0]), 32'h10);
        check("garb_last_addr", 32'(wa[11]), 32'h10B);
        check("garb_done", 32'(n_done), 1);
        check("garb_errs", {30'd0, err_line, err_frame}, 0);

        // Backpressure mid-line 1
        clear_log();
        do_start();
        for (int i = 0; i < 12; i++) begin
            send_pix(8'(8'h20 + 8'(i)), i == 0, (i % 4) == 3);
            if (i == 5) begin
                @(posedge clk); #1;
                mem_ready = 1'b0;
                pix_valid = 1'b1; pix_data = 8'h26;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check($sformatf("bp_ready_low%0d", k), 32'(pix_ready), 0);
                    @(posedge clk); #1;
                end
                check("bp_no_write_during_stall", 32'(wa.size()), 6);
                mem_ready = 1'b1;
                pix_valid = 1'b0;
            end
        end
        idle(3);
        check("bp_nwr", 32'(wa.size()), 12);
        for (int i = 0; i < 12; i++) begin
            ea = 17'h100 + 17'(i);
            check($sformatf("bp_addr%0d", i), 32'(wa[i]), 32'(ea));
        end
        check("bp_data7", 32'(wd[7]), 32'h27);
        check("bp_done", 32'(n_done), 1);

        // Short line 0 (eol on its 3rd pixel)
        clear_log();
        do_start();
        for (int i = 0; i < 11; i++)
            send_pix(8'(8'h30 + 8'(i)), i == 0, (i == 2) || (i == 6) || (i == 10));
        idle(3);
        check("short_nwr", 32'(wa.size()), 11);
        for (int i = 0; i < 11; i++) begin
            ea = (i < 3) ? 17'h100 + 17'(i) : 17'h104 + 17'(i - 3);
            check($sformatf("short_addr%0d", i), 32'(wa[i]), 32'(ea));
        end
        check("short_err_line", 32'(err_line), 1);
        check("short_err_frame", 32'(err_frame), 0);
        check("short_done", 32'(n_done), 1);

        // Mid-frame SOF at pixel 6
        clear_log();
        do_start();
        check("sof_errs_cleared_by_start", {30'd0, err_line, err_frame}, 0);
        for (int i = 0; i < 6; i++) send_pix(8'(8'h40 + 8'(i)), i == 0, i == 3);
        for (int i = 0; i < 11; i++) send_pix(8'(8'h50 + 8'(i)), i == 0, (i % 4) == 3);
        idle(1);
        check("sof_no_done_early", 32'(n_done), 0);
        send_pix(8'h5B, 1'b0, 1'b1);
        idle(3);
        check("sof_nwr", 32'(wa.size()), 18);
        check("sof_restart_addr", 32'(wa[6]), 32'h100);
        check("sof_restart_data", 32'(wd[6]), 32'h50);
        check("sof_addr5", 32'(wa[5]), 32'h105);
        check("sof_last_addr", 32'(wa[17]), 32'h10B);
        check("sof_err_frame", 32'(err_frame), 1);
        check("sof_err_line", 32'(err_line), 0);
        check("sof_done", 32'(n_done), 1);

        // Reset mid-frame
        clear_log();
        do_start();
        for (int i = 0; i < 5; i++) send_pix(8'(8'h60 + 8'(i)), i == 0, i == 3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_outs", {25'd0, writepixel, busy, pix_ready, frame_done, err_line, err_frame, 1'b0}, 0);
        check("mrst_addr_data", {7'd0, mem_addr, mem_wdata}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1'b1; pix_data = 8'(8'h70 + 8'(i)); pix_sof = (i == 0);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0; pix_sof = 1'b0;
        idle(2);
        check("mrst_nwr", 32'(wa.size()), 5);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(n_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
